// File: rtl/nios_handshake_debug_access_arbiter.sv
// Two-requester round-robin arbiter in front of the Nios II OCI monitor port.
// One transaction in flight at a time; a bounded wait and a debugack gate keep
// the port from hanging when the monitor or CPU cannot service a request.
module nios_handshake_debug_access_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [1:0]          err,
    output logic [DATA_W-1:0]   rdata,
    input  logic                debugack,
    output logic                mon_go,
    output logic                mon_write,
    output logic [ADDR_W-1:0]   mon_addr,
    output logic [DATA_W-1:0]   mon_wdata,
    input  logic [DATA_W-1:0]   mon_rdata,
    input  logic                monitor_ready,
    input  logic                monitor_error,
    output logic                busy,
    output logic                timeout_seen
);

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t              state_q, state_d;
    logic                sel_q;
    logic                last_q;
    logic                dbg_ok_q;
    logic                perr_q;
    logic                tseen_q;
    logic [7:0]          timer_q;
    logic                mwrite_q;
    logic [ADDR_W-1:0]   maddr_q;
    logic [DATA_W-1:0]   mwdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                pick;
    logic                timer_hit;

    // Lone requester wins outright; on a tie the one not served last wins.
    assign pick      = (req == 2'b11) ? ~last_q : req[1];
    assign timer_hit = (timer_q == TimerLast);

    assign busy         = (state_q != StIdle);
    assign timeout_seen = tseen_q;
    assign rdata        = rdata_q;
    assign mon_write    = mwrite_q;
    assign mon_addr     = maddr_q;
    assign mon_wdata    = mwdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes; strobes only ever on bit sel_q.
    always_comb begin
        state_d = state_q;
        gnt     = 2'b00;
        done    = 2'b00;
        err     = 2'b00;
        mon_go  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) state_d = StIssue;
            end
            StIssue: begin
                gnt[sel_q] = 1'b1;
                mon_go     = dbg_ok_q;
                state_d    = dbg_ok_q ? StWait : StResp;
            end
            StWait: begin
                if (monitor_ready || timer_hit) state_d = StResp;
            end
            StResp: begin
                done[sel_q] = 1'b1;
                err[sel_q]  = perr_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Command capture, round-robin history, wait timer and response bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            dbg_ok_q <= 1'b0;
            perr_q   <= 1'b0;
            tseen_q  <= 1'b0;
            timer_q  <= 8'd0;
            mwrite_q <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req != 2'b00) begin
                        sel_q    <= pick;
                        dbg_ok_q <= debugack;
                        mwrite_q <= req_write[pick];
                        maddr_q  <= pick ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                        mwdata_q <= pick ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                    end
                end
                StIssue: begin
                    last_q  <= sel_q;
                    timer_q <= 8'd0;
                    // Not in debug: answer with an error without touching the monitor.
                    perr_q  <= ~dbg_ok_q;
                end
                StWait: begin
                    // Ready takes priority over a timeout landing on the same edge.
                    if (monitor_ready) begin
                        if (!mwrite_q) rdata_q <= mon_rdata;
                        perr_q <= monitor_error;
                    end else if (timer_hit) begin
                        perr_q  <= 1'b1;
                        tseen_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
